// File: rtl/zet_pkg.sv
// Shared definitions for the EMS SDRAM arbiter: FSM encoding, timeout default
// and the data word returned to a master whose cycle was aborted.
package zet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int          TIMEOUT_DEF = 255;
  localparam int          CNT_W       = 8;
  localparam logic [15:0] ERR_DATA    = 16'hFFFF;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way grant selector: gnt=0 selects m0, gnt=1 selects m1.
module arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       prio_i,
  output logic       gnt_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    gnt_o   = req_i[1];
    // On a tie, fixed priority favours m1; otherwise alternate away from last winner.
    if (&req_i) begin
      gnt_o = prio_i ? 1'b1 : ~last_i;
    end
  end

endmodule

// File: rtl/ems_sdram_arb.sv
// Two-master Wishbone arbiter in front of the SDRAM controller: one registered
// slave cycle per grant, one-cycle ack to the winner, abort after TIMEOUT cycles.
module ems_sdram_arb
  import zet_pkg::*;
#(
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter bit M1_PRIORITY = 1'b0
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [31:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic [15:0] m0_dat_o,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  output logic        m0_ack_o,
  input  logic [31:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  output logic        m1_ack_o,
  output logic [31:0] s_adr_o,
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  output logic [1:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  input  logic        s_ack_i,
  output logic        timeout_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic             gnt_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      s_adr_q;
  logic [15:0]      s_dat_q;
  logic [1:0]       s_sel_q;
  logic             s_cyc_q;
  logic             s_stb_q;
  logic             s_we_q;
  logic             m0_ack_q;
  logic             m1_ack_q;
  logic [15:0]      m0_dat_q;
  logic [15:0]      m1_dat_q;
  logic             timeout_q;

  logic [1:0] req;
  logic       arb_gnt;
  logic       arb_valid;

  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  arb_rr2 u_arb (
    .req_i  (req),
    .last_i (last_q),
    .prio_i (M1_PRIORITY),
    .gnt_o  (arb_gnt),
    .valid_o(arb_valid)
  );

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      s_adr_q   <= '0;
      s_dat_q   <= '0;
      s_sel_q   <= '0;
      s_cyc_q   <= 1'b0;
      s_stb_q   <= 1'b0;
      s_we_q    <= 1'b0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      m0_dat_q  <= '0;
      m1_dat_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            gnt_q   <= arb_gnt;
            last_q  <= arb_gnt;
            s_adr_q <= arb_gnt ? m1_adr_i : m0_adr_i;
            s_dat_q <= arb_gnt ? m1_dat_i : m0_dat_i;
            s_sel_q <= arb_gnt ? m1_sel_i : m0_sel_i;
            s_we_q  <= arb_gnt ? m1_we_i  : m0_we_i;
            s_cyc_q <= 1'b1;
            s_stb_q <= 1'b1;
            cnt_q   <= CNT_LOAD;
            state_q <= BUS;
          end
        end
        BUS: begin
          // Acks are raised here so they are visible for exactly the ACK cycle.
          if (s_ack_i || cnt_q == '0) begin
            s_cyc_q   <= 1'b0;
            s_stb_q   <= 1'b0;
            timeout_q <= ~s_ack_i;
            if (gnt_q) begin
              m1_dat_q <= s_ack_i ? s_dat_i : ERR_DATA;
              m1_ack_q <= 1'b1;
            end else begin
              m0_dat_q <= s_ack_i ? s_dat_i : ERR_DATA;
              m0_ack_q <= 1'b1;
            end
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_adr_o   = s_adr_q;
  assign s_dat_o   = s_dat_q;
  assign s_sel_o   = s_sel_q;
  assign s_cyc_o   = s_cyc_q;
  assign s_stb_o   = s_stb_q;
  assign s_we_o    = s_we_q;
  assign m0_ack_o  = m0_ack_q;
  assign m1_ack_o  = m1_ack_q;
  assign m0_dat_o  = m0_dat_q;
  assign m1_dat_o  = m1_dat_q;
  assign timeout_o = timeout_q;

endmodule
